wbuf_loader: RTL and testbench

Upstream feeder for the weight buffer. Accepts a load command (start row, beat count, bank stride) and a 64-bit weight stream with valid/ready. Emits the buffer's write port (`mem_write_req`, `mem_write_addr`, `mem_write_data`), striping consecutive beats across bank IDs before advancing the row. Sits between the DMA read path and the weight buffer; the controller uses `busy`/`done` to gate weight reads.

---
 rtl/wbuf_loader.sv | 177 +++++++++++++++++
 tb/tb_wbuf_loader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wbuf_loader.sv
// wbuf_loader: stripes a 64-bit weight stream across buffer banks, then rows.
// Optional stall counter output enabled by `define WBUF_LOADER_STALL_CNT_EN.
module wbuf_loader #(
    parameter int MEM_DATA_WIDTH = 64,
    parameter int BUF_ADDR_WIDTH = 9,
    parameter int BUF_ID_W       = 5,
    parameter int MEM_ADDR_WIDTH = BUF_ADDR_WIDTH + BUF_ID_W,
    parameter int LEN_W          = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [BUF_ADDR_WIDTH-1:0] cmd_base_row,
    input  logic [LEN_W-1:0]          cmd_num_words,
    input  logic [BUF_ID_W:0]         cmd_bank_count,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [MEM_DATA_WIDTH-1:0] s_data,
    input  logic                      s_last,
    output logic                      mem_write_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_write_addr,
    output logic [MEM_DATA_WIDTH-1:0] mem_write_data,
    output logic                      busy,
    output logic                      done,
    output logic                      err_last
`ifdef WBUF_LOADER_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_e;

    localparam logic [BUF_ID_W:0] NB_MAX = {1'b1, {BUF_ID_W{1'b0}}};

    state_e                    state_q, state_d;
    logic [BUF_ADDR_WIDTH-1:0] row_q, row_d;
    logic [BUF_ID_W-1:0]       bank_q, bank_d;
    logic [BUF_ID_W:0]         nb_q, nb_d;
    logic [LEN_W-1:0]          rem_q, rem_d;
    logic                      err_q, err_d;
    logic                      req_q, req_d;
    logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [MEM_DATA_WIDTH-1:0] data_q, data_d;
    logic                      done_q, done_d;
`ifdef WBUF_LOADER_STALL_CNT_EN
    logic [31:0]               stall_q, stall_d;
`endif

    logic              last_bank;
    logic              final_beat;
    logic [BUF_ID_W:0] nb_clamp;

    assign last_bank  = ({1'b0, bank_q} == (nb_q - (BUF_ID_W+1)'(1)));
    assign final_beat = (rem_q == LEN_W'(1));

    always_comb begin
        nb_clamp = cmd_bank_count;
        if (cmd_bank_count == '0 || cmd_bank_count > NB_MAX) begin
            nb_clamp = NB_MAX;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        bank_d  = bank_q;
        nb_d    = nb_q;
        rem_d   = rem_q;
        err_d   = err_q;
        req_d   = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        done_d  = (state_q == DONE);
`ifdef WBUF_LOADER_STALL_CNT_EN
        stall_d = stall_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    row_d   = cmd_base_row;
                    bank_d  = '0;
                    nb_d    = nb_clamp;
                    rem_d   = cmd_num_words;
                    err_d   = 1'b0;
                    state_d = (cmd_num_words == '0) ? DONE : LOAD;
`ifdef WBUF_LOADER_STALL_CNT_EN
                    stall_d = '0;
`endif
                end
            end
            LOAD: begin
                if (s_valid) begin
                    req_d  = 1'b1;
                    addr_d = {row_q, bank_q};
                    data_d = s_data;
                    rem_d  = rem_q - LEN_W'(1);
                    if (last_bank) begin
                        bank_d = '0;
                        row_d  = row_q + BUF_ADDR_WIDTH'(1);
                    end else begin
                        bank_d = bank_q + BUF_ID_W'(1);
                    end
                    // s_last is only checked, never used to end the load
                    if (s_last != final_beat) begin
                        err_d = 1'b1;
                    end
                    if (final_beat) begin
                        state_d = DONE;
                    end
                end else begin
`ifdef WBUF_LOADER_STALL_CNT_EN
                    if (stall_q != '1) begin
                        stall_d = stall_q + 32'd1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            row_q   <= '0;
            bank_q  <= '0;
            nb_q    <= '0;
            rem_q   <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
`ifdef WBUF_LOADER_STALL_CNT_EN
            stall_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            bank_q  <= bank_d;
            nb_q    <= nb_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
`ifdef WBUF_LOADER_STALL_CNT_EN
            stall_q <= stall_d;
`endif
        end
    end

    assign cmd_ready      = (state_q == IDLE);
    assign s_ready        = (state_q == LOAD);
    assign busy           = (state_q != IDLE);
    assign done           = done_q;
    assign err_last       = err_q;
    assign mem_write_req  = req_q;
    assign mem_write_addr = addr_q;
    assign mem_write_data = data_q;
`ifdef WBUF_LOADER_STALL_CNT_EN
    assign stall_cycles   = stall_q;
`endif

endmodule

// File: tb/tb_wbuf_loader.sv
// tb_wbuf_loader: directed stimulus, write-port scoreboard for wbuf_loader.
// Expected addresses are hand-computed {row, bank} values per beat.
module tb_wbuf_loader;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [8:0]  cmd_base_row;
    logic [15:0] cmd_num_words;
    logic [5:0]  cmd_bank_count;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_data;
    logic        s_last;
    logic        mem_write_req;
    logic [13:0] mem_write_addr;
    logic [63:0] mem_write_data;
    logic        busy;
    logic        done;
    logic        err_last;
`ifdef WBUF_LOADER_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    wbuf_loader dut (
        .clk            (clk),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_base_row   (cmd_base_row),
        .cmd_num_words  (cmd_num_words),
        .cmd_bank_count (cmd_bank_count),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .s_last         (s_last),
        .mem_write_req  (mem_write_req),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .busy           (busy),
        .done           (done),
        .err_last       (err_last)
`ifdef WBUF_LOADER_STALL_CNT_EN
        ,
        .stall_cycles   (stall_cycles)
`endif
    );

    typedef struct {
        logic [13:0] addr;
        logic [63:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk;
    int   n_fail;
    int   done_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per observed write strobe
    always @(negedge clk) begin
        if (reset) begin
            if (done) done_cnt++;
            if (mem_write_req) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0h",
                             mem_write_addr, mem_write_data);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("wr_addr", 64'(mem_write_addr), 64'(e.addr));
                    chk("wr_data", mem_write_data, e.data);
                end
            end
        end
    end

    function automatic logic [63:0] mkd(input int i);
        return {32'hC0DE_0000 + 32'(i), ~32'(i)};
    endfunction

    task automatic cmd(input logic [8:0] base, input logic [15:0] n,
                       input logic [5:0] bc);
        chk("cmd_ready_before_cmd", 64'(cmd_ready), 64'd1);
        cmd_valid      = 1'b1;
        cmd_base_row   = base;
        cmd_num_words  = n;
        cmd_bank_count = bc;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic beat(input logic [63:0] d, input logic l,
                        input logic [13:0] a);
        int budget;
        exp_t e;
        budget = 0;
        while (!s_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!s_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL s_ready_timeout: got 0 expected 1");
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        e.addr  = a;
        e.data  = d;
        exp_q.push_back(e);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic expect_done(input string name);
        chk({name, "_busy_in_done"}, 64'(busy), 64'd1);
        chk({name, "_done_early"}, 64'(done), 64'd0);
        @(negedge clk);
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
        @(negedge clk);
        chk({name, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int d0;
        n_chk = 0;
        n_fail = 0;
        done_cnt = 0;
        reset = 1'b0;
        cmd_valid = 1'b0;
        cmd_base_row = '0;
        cmd_num_words = '0;
        cmd_bank_count = '0;
        s_valid = 1'b0;
        s_data = '0;
        s_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(mem_write_req), 64'd0);
        chk("rst_addr", 64'(mem_write_addr), 64'd0);
        chk("rst_data", mem_write_data, 64'd0);
        chk("rst_err", 64'(err_last), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        // Bank striping, 4 banks
        cmd(9'd0, 16'd8, 6'd4);
        chk("load_s_ready", 64'(s_ready), 64'd1);
        beat(mkd(0), 1'b0, 14'd0);
        beat(mkd(1), 1'b0, 14'd1);
        beat(mkd(2), 1'b0, 14'd2);
        beat(mkd(3), 1'b0, 14'd3);
        beat(mkd(4), 1'b0, 14'd32);
        beat(mkd(5), 1'b0, 14'd33);
        beat(mkd(6), 1'b0, 14'd34);
        beat(mkd(7), 1'b1, 14'd35);
        expect_done("stripe");
        chk("stripe_err", 64'(err_last), 64'd0);

        // Row wrap, single bank
        cmd(9'd511, 16'd3, 6'd1);
        beat(mkd(10), 1'b0, 14'd16352);
        beat(mkd(11), 1'b0, 14'd0);
        beat(mkd(12), 1'b1, 14'd32);
        expect_done("wrap");

        // Stream gaps, base row 2, 2 banks
        cmd(9'd2, 16'd6, 6'd2);
        beat(mkd(20), 1'b0, 14'd64);
        @(negedge clk);
        beat(mkd(21), 1'b0, 14'd65);
        @(negedge clk);
        beat(mkd(22), 1'b0, 14'd96);
        @(negedge clk);
        beat(mkd(23), 1'b0, 14'd97);
        @(negedge clk);
        beat(mkd(24), 1'b0, 14'd128);
        @(negedge clk);
        beat(mkd(25), 1'b1, 14'd129);
        expect_done("gaps");
`ifdef WBUF_LOADER_STALL_CNT_EN
        chk("stall_cycles", 64'(stall_cycles), 64'd5);
`endif

        // Zero length
        d0 = done_cnt;
        cmd(9'd7, 16'd0, 6'd4);
        expect_done("zero");
        chk("zero_done_count", 64'(done_cnt - d0), 64'd1);

        // Bank count 0 clamps to 32 banks
        cmd(9'd0, 16'd33, 6'd0);
        for (int i = 0; i < 33; i++) begin
            beat(mkd(100 + i), (i == 32), 14'(i));
        end
        expect_done("clamp0");

        // Bank count 40 also clamps to 32 banks
        cmd(9'd1, 16'd2, 6'd40);
        beat(mkd(200), 1'b0, 14'd32);
        beat(mkd(201), 1'b1, 14'd33);
        expect_done("clamp40");

        // Early s_last
        cmd(9'd3, 16'd4, 6'd4);
        beat(mkd(30), 1'b0, 14'd96);
        beat(mkd(31), 1'b1, 14'd97);
        beat(mkd(32), 1'b0, 14'd98);
        beat(mkd(33), 1'b0, 14'd99);
        expect_done("lasterr");
        chk("err_set", 64'(err_last), 64'd1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 64'(err_last), 64'd1);

        // Reset mid-load; new command also clears err_last
        cmd(9'd0, 16'd10, 6'd4);
        chk("err_cleared", 64'(err_last), 64'd0);
        beat(mkd(40), 1'b0, 14'd0);
        beat(mkd(41), 1'b0, 14'd1);
        beat(mkd(42), 1'b0, 14'd2);
        @(negedge clk);
        d0 = done_cnt;
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", 64'(mem_write_req), 64'd0);
        chk("mid_rst_addr", 64'(mem_write_addr), 64'd0);
        chk("mid_rst_data", mem_write_data, 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("mid_rst_done", 64'(done), 64'd0);
`ifdef WBUF_LOADER_STALL_CNT_EN
        chk("mid_rst_stall", 64'(stall_cycles), 64'd0);
`endif
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("mid_rst_idle", 64'(busy), 64'd0);
        cmd(9'd5, 16'd2, 6'd4);
        beat(mkd(50), 1'b0, 14'd160);
        beat(mkd(51), 1'b1, 14'd161);
        expect_done("after_rst");

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
